// File: rtl/sprite_fetch_seq.sv
// ----------------------------------------------------------------------------
// sprite_fetch_seq
//   Pattern-fetch address generator for the sprite engine. A start pulse
//   latches one sprite configuration plus the target scanline. One EVAL cycle
//   decides whether the scanline intersects the sprite. On a hit, one
//   pattern-memory read request per tile column is issued over a valid/ready
//   handshake. A one-cycle done pulse (with hit) closes every sequence.
//
//   Optional build macro: SPRITE_FETCH_ABORT_EN adds an abort input. Abort
//   cancels a sequence in EVAL/ISSUE and pulses done with hit=0.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle pulse; latches conf_* and row while IDLE
//   conf_tile       base tile {tile_y, tile_x}
//   conf_y          sprite top scanline
//   conf_w/conf_h   sprite width-1 / height-1 in tiles
//   conf_x_mirror   reverse column order
//   conf_y_mirror   vertical flip
//   row             scanline being fetched
//   abort           (SPRITE_FETCH_ABORT_EN only) cancel the current sequence
//   req_valid/req_ready  request handshake towards the VRAM arbiter
//   req_addr        {tile_y, tile_x, tile_row}
//   req_slot        on-screen slot of this pattern (0 = leftmost)
//   req_last        final request of this sprite row
//   busy            sequence in progress
//   done/hit        completion pulse; hit=1 when the row intersected the sprite
// ----------------------------------------------------------------------------
module sprite_fetch_seq #(
    parameter int COORD_W   = 5,
    parameter int W_FIELD_W = 2,
    parameter int H_FIELD_W = 2,
    parameter int ROW_W     = 8,
    parameter int ADDR_W    = 2*COORD_W+3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [2*COORD_W-1:0]   conf_tile,
    input  logic [ROW_W-1:0]       conf_y,
    input  logic [W_FIELD_W-1:0]   conf_w,
    input  logic [H_FIELD_W-1:0]   conf_h,
    input  logic                   conf_x_mirror,
    input  logic                   conf_y_mirror,
    input  logic [ROW_W-1:0]       row,
`ifdef SPRITE_FETCH_ABORT_EN
    input  logic                   abort,
`endif
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [ADDR_W-1:0]      req_addr,
    output logic [W_FIELD_W-1:0]   req_slot,
    output logic                   req_last,
    output logic                   busy,
    output logic                   done,
    output logic                   hit
);

    // Row index inside the sprite spans (h+1)*8 lines, so H_FIELD_W+3 bits.
    localparam int RI_W  = H_FIELD_W + 3;
    // Comparison width holds both the row offset and height_px (up to 2^RI_W).
    localparam int CMP_W = (ROW_W > RI_W + 1) ? ROW_W : RI_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        ISSUE = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [2*COORD_W-1:0]   tile_r;
    logic [ROW_W-1:0]       y_r;
    logic [W_FIELD_W-1:0]   w_r;
    logic [H_FIELD_W-1:0]   h_r;
    logic                   xm_r;
    logic                   ym_r;
    logic [ROW_W-1:0]       row_r;
    logic [RI_W-1:0]        row_idx_r;
    logic [W_FIELD_W-1:0]   k_r;
    logic                   hit_r;
    logic                   abort_done_r;

    logic                   abort_s;
    logic [ROW_W-1:0]       row_off_s;
    logic [CMP_W-1:0]       off_ext_s;
    logic [CMP_W-1:0]       height_s;
    logic                   miss_s;
    logic [CMP_W-1:0]       row_idx_full_s;
    logic [W_FIELD_W-1:0]   col_s;
    logic [COORD_W-1:0]     tile_x_s;
    logic [COORD_W-1:0]     tile_y_s;
    logic                   last_s;
    logic                   cancel_s;

`ifdef SPRITE_FETCH_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Abort only has an effect while a sequence is being evaluated or issued.
    assign cancel_s = abort_s && ((state_r == EVAL) || (state_r == ISSUE));

    // Hit test and row-index computation from the latched configuration.
    always_comb begin
        row_off_s      = row_r - y_r;
        off_ext_s      = CMP_W'(row_off_s);
        height_s       = (CMP_W'(h_r) + CMP_W'(1)) << 3;
        miss_s         = (off_ext_s >= height_s);
        if (ym_r) begin
            row_idx_full_s = height_s - CMP_W'(1) - off_ext_s;
        end else begin
            row_idx_full_s = off_ext_s;
        end
    end

    // Current request address: column order, tile wrap and tile-row split.
    always_comb begin
        if (xm_r) begin
            col_s = w_r - k_r;
        end else begin
            col_s = k_r;
        end
        tile_x_s = tile_r[COORD_W-1:0] + COORD_W'(col_s);
        tile_y_s = tile_r[2*COORD_W-1:COORD_W] + COORD_W'(row_idx_r[RI_W-1:3]);
        last_s   = (k_r == w_r);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; abort outranks a simultaneous handshake.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = EVAL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EVAL: begin
                if (cancel_s) begin
                    state_nxt_s = IDLE;
                end else if (miss_s) begin
                    state_nxt_s = FIN;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            ISSUE: begin
                if (cancel_s) begin
                    state_nxt_s = IDLE;
                end else if (req_ready && last_s) begin
                    state_nxt_s = FIN;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            FIN:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Configuration latch, row index, column counter and completion flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_r       <= '0;
            y_r          <= '0;
            w_r          <= '0;
            h_r          <= '0;
            xm_r         <= 1'b0;
            ym_r         <= 1'b0;
            row_r        <= '0;
            row_idx_r    <= '0;
            k_r          <= '0;
            hit_r        <= 1'b0;
            abort_done_r <= 1'b0;
        end else begin
            abort_done_r <= cancel_s;
            if ((state_r == IDLE) && start) begin
                tile_r <= conf_tile;
                y_r    <= conf_y;
                w_r    <= conf_w;
                h_r    <= conf_h;
                xm_r   <= conf_x_mirror;
                ym_r   <= conf_y_mirror;
                row_r  <= row;
            end else if (state_r == EVAL) begin
                row_idx_r <= RI_W'(row_idx_full_s);
                hit_r     <= !miss_s;
                k_r       <= '0;
            end else if ((state_r == ISSUE) && req_ready && !last_s) begin
                k_r <= k_r + W_FIELD_W'(1);
            end else begin
                k_r <= k_r;
            end
        end
    end

    // Outputs decoded only from registered state, zero outside their phase.
    always_comb begin
        req_valid = (state_r == ISSUE);
        if (state_r == ISSUE) begin
            req_addr = {tile_y_s, tile_x_s, row_idx_r[2:0]};
            req_slot = k_r;
            req_last = last_s;
        end else begin
            req_addr = '0;
            req_slot = '0;
            req_last = 1'b0;
        end
        busy = (state_r != IDLE);
        done = (state_r == FIN) || abort_done_r;
        hit  = (state_r == FIN) && hit_r;
    end

endmodule

// File: tb/tb_sprite_fetch_seq.sv
// ----------------------------------------------------------------------------
// tb_sprite_fetch_seq
//   Directed bench for sprite_fetch_seq. Inputs are driven 1 time unit after
//   the rising edge. Outputs are compared at that same point, because they
//   depend only on registered state.
//   Address layout: {tile_y[4:0], tile_x[4:0], tile_row[2:0]}.
// ----------------------------------------------------------------------------
module tb_sprite_fetch_seq;

    localparam int COORD_W   = 5;
    localparam int W_FIELD_W = 2;
    localparam int H_FIELD_W = 2;
    localparam int ROW_W     = 8;
    localparam int ADDR_W    = 2*COORD_W+3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [2*COORD_W-1:0] conf_tile;
    logic [ROW_W-1:0]     conf_y;
    logic [W_FIELD_W-1:0] conf_w;
    logic [H_FIELD_W-1:0] conf_h;
    logic                 conf_x_mirror;
    logic                 conf_y_mirror;
    logic [ROW_W-1:0]     row;
    logic                 abort;
    logic                 req_valid;
    logic                 req_ready;
    logic [ADDR_W-1:0]    req_addr;
    logic [W_FIELD_W-1:0] req_slot;
    logic                 req_last;
    logic                 busy;
    logic                 done;
    logic                 hit;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    sprite_fetch_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .conf_tile     (conf_tile),
        .conf_y        (conf_y),
        .conf_w        (conf_w),
        .conf_h        (conf_h),
        .conf_x_mirror (conf_x_mirror),
        .conf_y_mirror (conf_y_mirror),
        .row           (row),
`ifdef SPRITE_FETCH_ABORT_EN
        .abort         (abort),
`endif
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_slot      (req_slot),
        .req_last      (req_last),
        .busy          (busy),
        .done          (done),
        .hit           (hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_req(input string tag, input logic [31:0] addr,
                           input logic [31:0] slot, input logic [31:0] last);
        chk({tag, "_valid"}, 32'(req_valid), 32'd1);
        chk({tag, "_addr"},  32'(req_addr),  addr);
        chk({tag, "_slot"},  32'(req_slot),  slot);
        chk({tag, "_last"},  32'(req_last),  last);
    endtask

    task automatic chk_done(input string tag, input logic [31:0] exp_hit);
        chk({tag, "_done"},  32'(done),      32'd1);
        chk({tag, "_hit"},   32'(hit),       exp_hit);
        chk({tag, "_valid"}, 32'(req_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd1);
    endtask

    // Drive one start pulse; returns in cycle N+1 (EVAL).
    task automatic start_seq(input logic [9:0] t, input logic [7:0] y, input logic [1:0] w,
                             input logic [1:0] h, input logic xm, input logic ym,
                             input logic [7:0] r);
        conf_tile = t; conf_y = y; conf_w = w; conf_h = h;
        conf_x_mirror = xm; conf_y_mirror = ym; row = r;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("eval_busy",  32'(busy),      32'd1);
        chk("eval_valid", 32'(req_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; req_ready = 1'b0;
        conf_tile = '0; conf_y = '0; conf_w = '0; conf_h = '0;
        conf_x_mirror = 1'b0; conf_y_mirror = 1'b0; row = '0;

        // Reset state
        tick(); tick();
        chk("rst_valid", 32'(req_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_hit",   32'(hit),       32'd0);
        chk("rst_last",  32'(req_last),  32'd0);
        chk("rst_addr",  32'(req_addr),  32'd0);
        chk("rst_slot",  32'(req_slot),  32'd0);
        rst_n = 1'b1;
        tick();

        // Reset mid-ISSUE at k=1 of 4 columns
        req_ready = 1'b1;
        start_seq(10'h000, 8'd0, 2'd3, 2'd0, 1'b0, 1'b0, 8'd0);
        tick();
        chk_req("mid_k0", 32'h0000, 32'd0, 32'd0);
        tick();
        chk_req("mid_k1", 32'h0008, 32'd1, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(req_valid), 32'd0);
        chk("arst_busy",  32'(busy),      32'd0);
        chk("arst_done",  32'(done),      32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Basic two-column hit: offset 3, row_index 3
        start_seq(10'h000, 8'd10, 2'd1, 2'd0, 1'b0, 1'b0, 8'd13);
        tick();
        chk_req("a_r0", 32'h0003, 32'd0, 32'd0);
        tick();
        chk_req("a_r1", 32'h000B, 32'd1, 32'd1);
        tick();
        chk_done("a_fin", 32'd1);
        tick();
        chk("a_idle_busy", 32'(busy), 32'd0);
        chk("a_idle_done", 32'(done), 32'd0);

        // Vertical flip: row_index = 7 - 3 = 4
        start_seq(10'h000, 8'd10, 2'd1, 2'd0, 1'b0, 1'b1, 8'd13);
        tick();
        chk_req("b_r0", 32'h0004, 32'd0, 32'd0);
        tick();
        chk_req("b_r1", 32'h000C, 32'd1, 32'd1);
        tick();
        chk_done("b_fin", 32'd1);
        tick();

        // Horizontal mirror with tile_x wrap: tile_x 1, 0, 31 at tile_y 2
        start_seq(10'h05F, 8'd40, 2'd2, 2'd0, 1'b1, 1'b0, 8'd40);
        tick();
        chk_req("c_r0", 32'h0208, 32'd0, 32'd0);
        tick();
        chk_req("c_r1", 32'h0200, 32'd1, 32'd0);
        tick();
        chk_req("c_r2", 32'h02F8, 32'd2, 32'd1);
        tick();
        chk_done("c_fin", 32'd1);
        tick();

        // Single column, tall sprite: offset 19 -> tile_y +2, tile_row 3
        start_seq(10'h000, 8'h20, 2'd0, 2'd3, 1'b0, 1'b0, 8'h33);
        tick();
        chk_req("d_r0", 32'h0203, 32'd0, 32'd1);
        tick();
        chk_done("d_fin", 32'd1);
        tick();

        // Miss by wrap-around: offset 255 >= 32
        start_seq(10'h000, 8'd10, 2'd1, 2'd3, 1'b0, 1'b0, 8'd9);
        tick();
        chk_done("e_fin", 32'd0);
        tick();
        chk("e_idle_busy", 32'(busy), 32'd0);

        // Miss at exact boundary: offset 8 == height_px
        start_seq(10'h000, 8'd10, 2'd1, 2'd0, 1'b0, 1'b0, 8'd18);
        tick();
        chk_done("f_fin", 32'd0);
        tick();

        // Back-pressure for 3 cycles plus an ignored start mid-sequence
        req_ready = 1'b0;
        start_seq(10'h000, 8'd10, 2'd1, 2'd0, 1'b0, 1'b0, 8'd13);
        tick();
        chk_req("g_w0", 32'h0003, 32'd0, 32'd0);
        conf_tile = 10'h3FF; conf_w = 2'd3; row = 8'd200; start = 1'b1;
        tick();
        start = 1'b0;
        chk_req("g_w1", 32'h0003, 32'd0, 32'd0);
        tick();
        chk_req("g_w2", 32'h0003, 32'd0, 32'd0);
        req_ready = 1'b1;
        tick();
        chk_req("g_r1", 32'h000B, 32'd1, 32'd1);
        tick();
        chk_done("g_fin", 32'd1);
        tick();
        chk("g_idle_busy",  32'(busy),      32'd0);
        chk("g_idle_valid", 32'(req_valid), 32'd0);

`ifdef SPRITE_FETCH_ABORT_EN
        // Abort during ISSUE, simultaneous with an accepted handshake
        start_seq(10'h000, 8'd10, 2'd1, 2'd0, 1'b0, 1'b0, 8'd13);
        tick();
        chk_req("h_r0", 32'h0003, 32'd0, 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("h_valid", 32'(req_valid), 32'd0);
        chk("h_done",  32'(done),      32'd1);
        chk("h_hit",   32'(hit),       32'd0);
        chk("h_busy",  32'(busy),      32'd0);
        tick();
        chk("h_done_end", 32'(done), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
